aes_key_expand: RTL and testbench

- Iterative AES-128 key schedule.
- Takes a 128-bit cipher key and produces round keys 0..10, one new round key per clock.
- Stores all 11 round keys in an internal register file and serves them to the round datapath through a registered read port.
- Contains four sbox_mux instances that implement SubWord, and feeds the cipher round stage, which consumes the round keys.

---
 rtl/aes_key_expand_if.sv | 23 ++
 rtl/aes_key_expand.sv | 171 +++++++++++++++++
 tb/tb_aes_key_expand.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_expand_if.sv
// Request/response bundle between the key schedule and its user:
// key load handshake, status flags and the registered round-key read port.
interface aes_key_expand_if #(
    parameter int unsigned AW = 4
);
    logic          start;
    logic [127:0]  key_in;
    logic          busy;
    logic          done;
    logic          key_valid;
    logic [AW-1:0] rk_addr;
    logic [127:0]  rk_out;

    modport master (
        output start, key_in, rk_addr,
        input  busy, done, key_valid, rk_out
    );

    modport slave (
        input  start, key_in, rk_addr,
        output busy, done, key_valid, rk_out
    );
endinterface

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into an
// 11-entry register file, served through a registered read port.
module sbox_mux (
    input  logic [7:0] a,
    output logic [7:0] q
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign q = SBOX[a];
endmodule

module aes_key_expand #(
    parameter int unsigned NR = 10,
    parameter int unsigned AW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    aes_key_expand_if.slave bus
);
    localparam int unsigned KW  = 128;
    localparam int unsigned NRK = NR + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] rnd_q, rnd_d;
    logic [7:0]    rcon_q, rcon_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          valid_q, valid_d;
    logic [KW-1:0] rk_q [NRK];
    logic [KW-1:0] rk_out_q;

    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [KW-1:0] wr_data;

    logic [AW-1:0] prev_idx;
    logic [KW-1:0] prev_key;
    logic [31:0]   w0, w1, w2, w3;
    logic [31:0]   rot_w, sub_w, t_w;
    logic [31:0]   n0, n1, n2, n3;
    logic [KW-1:0] next_key;
    logic [7:0]    rcon_next;

    // Previous round key; rnd is 0 only out of reset, where the value is unused
    assign prev_idx = rnd_q - AW'(1);
    assign prev_key = (prev_idx < AW'(NRK)) ? rk_q[prev_idx] : '0;
    assign {w0, w1, w2, w3} = prev_key;

    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_subword
        sbox_mux u_sbox (
            .a(rot_w[8*g +: 8]),
            .q(sub_w[8*g +: 8])
        );
    end

    assign t_w       = sub_w ^ {rcon_q, 24'h0};
    assign n0        = w0 ^ t_w;
    assign n1        = w1 ^ n0;
    assign n2        = w2 ^ n1;
    assign n3        = w3 ^ n2;
    assign next_key  = {n0, n1, n2, n3};
    assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

    // Next-state, counters and register-file write control
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        rcon_d  = rcon_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        wr_en   = 1'b0;
        wr_idx  = rnd_q;
        wr_data = next_key;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    wr_en   = 1'b1;
                    wr_idx  = '0;
                    wr_data = bus.key_in;
                    rnd_d   = AW'(1);
                    rcon_d  = 8'h01;
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                wr_en  = 1'b1;
                rnd_d  = rnd_q + AW'(1);
                rcon_d = rcon_next;
                if (rnd_q == AW'(NR)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            rcon_q  <= 8'h01;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            rcon_q  <= rcon_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    // Round-key register file; reset clears any partial schedule
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NRK); i++) begin
                rk_q[i] <= '0;
            end
        end else if (wr_en && (wr_idx < AW'(NRK))) begin
            rk_q[wr_idx] <= wr_data;
        end
    end

    // Registered read port; out-of-range indices read as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_out_q <= '0;
        end else if (bus.rk_addr < AW'(NRK)) begin
            rk_out_q <= rk_q[bus.rk_addr];
        end else begin
            rk_out_q <= '0;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.key_valid = valid_q;
    assign bus.rk_out    = rk_out_q;
endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 style word-array key schedule model
// compared against the DUT every cycle, plus literal test vectors.
module tb_aes_key_expand;
    typedef logic [10:0][127:0] ks_t;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_key_expand_if #(.AW(4)) bus ();
    aes_key_expand #(.NR(10), .AW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic ks_t expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] temp;
        logic [7:0]  rc = 8'h01;
        ks_t ks;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sb[temp[31:24]], sb[temp[23:16]], sb[temp[15:8]], sb[temp[7:0]]};
                temp = temp ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    // Cycle model: the whole schedule is known on acceptance and revealed one key per edge
    ks_t          m_rk, m_pend;
    logic         m_busy, m_done, m_valid;
    logic [127:0] m_out;
    int           m_idx;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rk    <= '0;
            m_pend  <= '0;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_valid <= 1'b0;
            m_out   <= '0;
            m_idx   <= 0;
        end else begin
            m_out  <= (bus.rk_addr <= 4'd10) ? m_rk[int'(bus.rk_addr)] : '0;
            m_done <= 1'b0;
            if (!m_busy) begin
                if (bus.start) begin
                    m_pend  <= expand_key(bus.key_in);
                    m_rk[0] <= bus.key_in;
                    m_idx   <= 1;
                    m_busy  <= 1'b1;
                    m_valid <= 1'b0;
                end
            end else begin
                m_rk[m_idx] <= m_pend[m_idx];
                m_idx <= m_idx + 1;
                if (m_idx == 10) begin
                    m_busy  <= 1'b0;
                    m_done  <= 1'b1;
                    m_valid <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 128'(bus.busy), 128'(m_busy));
        check("done", 128'(bus.done), 128'(m_done));
        check("key_valid", 128'(bus.key_valid), 128'(m_valid));
        check("rk_out", bus.rk_out, m_out);
    end

    task automatic read_addr(input logic [3:0] a, input logic [127:0] exp, input string name);
        @(negedge clk);
        bus.rk_addr = a;
        @(negedge clk);
        check(name, bus.rk_out, exp);
    endtask

    task automatic pulse_start(input logic [127:0] key);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.key_in = key;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    // Called at the negedge just after the accepting edge
    task automatic wait_done(input string name);
        int n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(name, 128'(n), 128'd10);
    endtask

    ks_t fips_ks, zero_ks;

    initial begin
        bus.start   = 1'b0;
        bus.key_in  = '0;
        bus.rk_addr = '0;
        for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
        fips_ks = expand_key(FIPS_KEY);
        zero_ks = expand_key('0);

        // Pin the model itself
        check("model_sbox_00", 128'(sb[8'h00]), 128'h63);
        check("model_sbox_53", 128'(sb[8'h53]), 128'hed);
        check("model_fips_rk1", fips_ks[1], FIPS_RK1);
        check("model_fips_rk10", fips_ks[10], FIPS_RK10);
        check("model_zero_rk1", zero_ks[1], ZERO_RK1);
        check("model_zero_rk10", zero_ks[10], ZERO_RK10);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i <= 10; i++) read_addr(4'(i), '0, "reset_read");

        pulse_start(FIPS_KEY);
        wait_done("fips_done_latency");
        check("fips_key_valid", 128'(bus.key_valid), 128'd1);
        read_addr(4'd1, FIPS_RK1, "fips_rk1");
        read_addr(4'd10, FIPS_RK10, "fips_rk10");
        read_addr(4'd0, FIPS_KEY, "fips_rk0");

        // Zero key, with a FIPS start attempted while busy
        pulse_start('0);
        repeat (3) @(negedge clk);
        bus.start  = 1'b1;
        bus.key_in = FIPS_KEY;
        @(negedge clk);
        bus.start  = 1'b0;
        check("busy_during_ignored_start", 128'(bus.busy), 128'd1);
        begin
            int n = 0;
            while (!bus.done && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("zero_done_seen", 128'(bus.done), 128'd1);
        end
        // Start in the done cycle
        bus.start  = 1'b1;
        bus.key_in = FIPS_KEY;
        @(negedge clk);
        bus.start  = 1'b0;
        check("valid_drop_on_restart", 128'(bus.key_valid), 128'd0);
        check("zero_rk1_while_restart", m_rk[1], ZERO_RK1);
        wait_done("restart_done_latency");
        read_addr(4'd1, FIPS_RK1, "restart_rk1");
        read_addr(4'd10, FIPS_RK10, "restart_rk10");

        // Zero-key schedule check before reset test
        pulse_start('0);
        wait_done("zero_done_latency");
        read_addr(4'd1, ZERO_RK1, "zero_rk1");
        read_addr(4'd10, ZERO_RK10, "zero_rk10");

        // Reset mid-expansion
        bus.rk_addr = 4'd0;
        pulse_start(FIPS_KEY);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_done", 128'(bus.done), 128'd0);
        check("rst_key_valid", 128'(bus.key_valid), 128'd0);
        check("rst_rk_out", bus.rk_out, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("post_rst_busy", 128'(bus.busy), 128'd0);
        read_addr(4'd1, '0, "post_rst_rk1");

        // Out-of-range addresses and a sweeping read address
        pulse_start(FIPS_KEY);
        wait_done("sweep_done_latency");
        read_addr(4'd11, '0, "addr11");
        read_addr(4'd15, '0, "addr15");
        @(negedge clk);
        for (int i = 10; i >= 0; i--) begin
            bus.rk_addr = 4'(i);
            @(negedge clk);
            check("sweep_read", bus.rk_out, fips_ks[i]);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
